// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Multi-cycle adder: adds two WIDTH-bit operands DIGIT bits per clock,
//   LSB slice first, through a ripple of full-adder cells. One operation
//   takes N = WIDTH/DIGIT ADD cycles plus one DONE cycle.
//
//   Optional feature: define SERIAL_ADDER_SUB_EN to add the "sub" port.
//   With sub=1 the block computes a + ~b + 1 and ignores cin. cout=1 then
//   means "no borrow".
//
// Parameters
//   WIDTH  operand/result width (>= 2)
//   DIGIT  bits added per clock; WIDTH must be a multiple of DIGIT
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  begin one addition (accepted in IDLE or DONE)
//   a, b   operands, captured on an accepted start
//   cin    carry-in, captured on an accepted start
//   sub    (SERIAL_ADDER_SUB_EN only) subtract select, captured with start
//   busy   high while the ADD state is active
//   done   one-cycle pulse when sum/cout have just been updated
//   sum    registered result, held between operations
//   cout   registered carry-out of the MSB
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int N  = WIDTH / DIGIT;
    // Wide enough to hold N itself, so the counter never wraps mid-operation.
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [DIGIT:0]   step_s;
    logic [WIDTH-1:0] slice_ext_s;
    logic [WIDTH-1:0] b_in_s;
    logic             cin_in_s;

    // Ripple of full-adder cells over one DIGIT-bit slice; returns {carry, sum}.
    function automatic logic [DIGIT:0] digit_add(
        input logic [DIGIT-1:0] x,
        input logic [DIGIT-1:0] y,
        input logic             c_in
    );
        logic             c;
        logic [DIGIT-1:0] s;
        c = c_in;
        s = {DIGIT{1'b0}};
        for (int i = 0; i < DIGIT; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, s};
    endfunction

    // Operand B / carry-in as seen by the datapath (subtract inverts B, forces +1).
    always_comb begin
        b_in_s   = b;
        cin_in_s = cin;
`ifdef SERIAL_ADDER_SUB_EN
        if (sub) begin
            b_in_s   = ~b;
            cin_in_s = 1'b1;
        end else begin
            b_in_s   = b;
            cin_in_s = cin;
        end
`endif
    end

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;

        step_s                    = digit_add(a_q[DIGIT-1:0], b_q[DIGIT-1:0], carry_q);
        slice_ext_s               = {WIDTH{1'b0}};
        slice_ext_s[DIGIT-1:0]    = step_s[DIGIT-1:0];

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b_in_s;
                    carry_d = cin_in_s;
                    acc_d   = {WIDTH{1'b0}};
                    cnt_d   = {CW{1'b0}};
                    state_d = ADD;
                end else begin
                    state_d = IDLE;
                end
            end
            ADD: begin
                // Operands shift down so the next slice is always at the LSBs;
                // results enter at the top so the first slice ends at the bottom.
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                acc_d   = (acc_q >> DIGIT) | (slice_ext_s << (WIDTH - DIGIT));
                carry_d = step_s[DIGIT];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                    sum_d   = acc_d;
                    cout_d  = step_s[DIGIT];
                end else begin
                    state_d = ADD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == ADD);
        done_d = (state_d == DONE);
    end

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            acc_q   <= {WIDTH{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            cnt_q   <= {CW{1'b0}};
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Directed bench for serial_adder: one WIDTH=8/DIGIT=1 instance and one
//   WIDTH=16/DIGIT=4 instance sharing clock and reset. Expected values are
//   hand-computed constants.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    logic        clk;
    logic        rst_n;

    logic        start8, cin8, busy8, done8, cout8;
    logic [7:0]  a8, b8, sum8;
    logic        start16, cin16, busy16, done16, cout16;
    logic [15:0] a16, b16, sum16;
`ifdef SERIAL_ADDER_SUB_EN
    logic        sub8, sub16;
`endif

    int          n_cmp;
    int          n_err;
    logic [7:0]  last_sum8;
    logic [15:0] last_sum16;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub8),
`endif
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start16),
        .a     (a16),
        .b     (b16),
        .cin   (cin16),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub16),
`endif
        .busy  (busy16),
        .done  (done16),
        .sum   (sum16),
        .cout  (cout16)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One 8-bit operation; operands are scrambled right after acceptance.
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                        input logic ts, input logic [7:0] es, input logic ec, input string tag);
        int cnt;
        a8 = ta; b8 = tb; cin8 = tc;
`ifdef SERIAL_ADDER_SUB_EN
        sub8 = ts;
`else
        if (ts) $display("note: sub requested without subtract support");
`endif
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        a8 = ~ta; b8 = 8'h5A; cin8 = ~tc;
`ifdef SERIAL_ADDER_SUB_EN
        sub8 = ~ts;
`endif
        cnt = 0;
        while (busy8 && cnt < 20) begin
            cnt++;
            if (cnt == 4) check_eq({tag, "_hold"}, 32'(sum8), 32'(last_sum8));
            step();
        end
        check_eq({tag, "_busy_cycles"}, 32'(cnt), 32'd8);
        check_eq({tag, "_done"}, 32'(done8), 32'd1);
        check_eq({tag, "_sum"}, 32'(sum8), 32'(es));
        check_eq({tag, "_cout"}, 32'(cout8), 32'(ec));
        last_sum8 = es;
        step();
        check_eq({tag, "_done_off"}, 32'(done8), 32'd0);
        check_eq({tag, "_idle"}, 32'(busy8), 32'd0);
    endtask

    // One 16-bit operation with a stray start pulse during ADD.
    task automatic run16(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                         input logic [15:0] es, input logic ec, input string tag);
        int cnt;
        a16 = ta; b16 = tb; cin16 = tc;
        start16 = 1'b1;
        step();
        start16 = 1'b0;
        a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1'b1;
        cnt = 0;
        while (busy16 && cnt < 20) begin
            cnt++;
            if (cnt == 2) begin
                start16 = 1'b1;
                check_eq({tag, "_hold"}, 32'(sum16), 32'(last_sum16));
            end else begin
                start16 = 1'b0;
            end
            step();
        end
        start16 = 1'b0;
        check_eq({tag, "_busy_cycles"}, 32'(cnt), 32'd4);
        check_eq({tag, "_done"}, 32'(done16), 32'd1);
        check_eq({tag, "_sum"}, 32'(sum16), 32'(es));
        check_eq({tag, "_cout"}, 32'(cout16), 32'(ec));
        last_sum16 = es;
        step();
        check_eq({tag, "_done_off"}, 32'(done16), 32'd0);
        check_eq({tag, "_idle"}, 32'(busy16), 32'd0);
    endtask

    // Main directed sequence.
    initial begin
        logic [7:0] bb_a  [3];
        logic [7:0] bb_b  [3];
        logic       bb_c  [3];
        logic [7:0] bb_s  [3];
        logic       bb_co [3];
        int         cyc;
        int         dcnt;

        n_cmp = 0; n_err = 0;
        last_sum8 = 8'h00; last_sum16 = 16'h0000;
        rst_n = 1'b0;
        start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        start16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000; cin16 = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub8 = 1'b0; sub16 = 1'b0;
`endif
        #3;
        check_eq("rst_sum8", 32'(sum8), 32'd0);
        check_eq("rst_cout8", 32'(cout8), 32'd0);
        check_eq("rst_busy8", 32'(busy8), 32'd0);
        check_eq("rst_done8", 32'(done8), 32'd0);
        check_eq("rst_sum16", 32'(sum16), 32'd0);
        #20;
        rst_n = 1'b1;

        run8(8'h3C, 8'h0F, 1'b0, 1'b0, 8'h4B, 1'b0, "add_3c_0f");
        run8(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, "add_ff_00_c");
        run8(8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, "add_ff_01_c");

        run16(16'h1234, 16'hEDCC, 1'b0, 16'h0000, 1'b1, "w16_wrap");
        run16(16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, "w16_plain");

        // Reset after 3 of 8 ADD steps.
        a8 = 8'h55; b8 = 8'h11; cin8 = 1'b0;
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        step(); step(); step();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_sum", 32'(sum8), 32'd0);
        check_eq("midrst_cout", 32'(cout8), 32'd0);
        check_eq("midrst_busy", 32'(busy8), 32'd0);
        check_eq("midrst_done", 32'(done8), 32'd0);
        #20;
        rst_n = 1'b1;
        last_sum8 = 8'h00;
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (done8 || busy8) dcnt++;
        end
        check_eq("midrst_no_done", 32'(dcnt), 32'd0);
        run8(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, "after_rst");

        // Back-to-back with start held high.
        bb_a[0] = 8'h10; bb_b[0] = 8'h20; bb_c[0] = 1'b0; bb_s[0] = 8'h30; bb_co[0] = 1'b0;
        bb_a[1] = 8'h80; bb_b[1] = 8'h80; bb_c[1] = 1'b1; bb_s[1] = 8'h01; bb_co[1] = 1'b1;
        bb_a[2] = 8'h7F; bb_b[2] = 8'h01; bb_c[2] = 1'b0; bb_s[2] = 8'h80; bb_co[2] = 1'b0;
        a8 = bb_a[0]; b8 = bb_b[0]; cin8 = bb_c[0];
        start8 = 1'b1;
        step();
        a8 = bb_a[1]; b8 = bb_b[1]; cin8 = bb_c[1];
        cyc = 0;
        for (int k = 0; k < 3; k++) begin
            do begin
                step();
                cyc++;
            end while (!done8 && cyc < 30);
            check_eq($sformatf("b2b%0d_period", k), 32'(cyc), (k == 0) ? 32'd8 : 32'd9);
            check_eq($sformatf("b2b%0d_sum", k), 32'(sum8), 32'(bb_s[k]));
            check_eq($sformatf("b2b%0d_cout", k), 32'(cout8), 32'(bb_co[k]));
            if (k < 2) begin
                step();
                check_eq($sformatf("b2b%0d_accept", k), 32'(busy8), 32'd1);
                cyc = 1;
                if (k == 0) begin
                    a8 = bb_a[2]; b8 = bb_b[2]; cin8 = bb_c[2];
                end else begin
                    start8 = 1'b0;
                end
            end else begin
                start8 = 1'b0;
            end
        end
        step();
        check_eq("b2b_end_idle", 32'(busy8), 32'd0);
        last_sum8 = 8'h80;

`ifdef SERIAL_ADDER_SUB_EN
        run8(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, "sub_5_7");
        run8(8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1, "sub_7_5");
        sub8 = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
